// File: rtl/ifetch_prefetch_pkg.sv
// Shared types and constants for the prefetching instruction fetch stage.
// Contents: fetch FSM state, fault cause codes, the queue-entry struct and the
// PC step.
// The entry struct fixes the XLEN/ILEN widths. Any top-level override of XLEN
// or ILEN must match PKG_XLEN/PKG_ILEN.
package ifetch_pkg;

  localparam int PKG_XLEN = 64;
  localparam int PKG_ILEN = 32;
  localparam int PC_STEP  = 4;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_ACCESS   = 2'd1,
    CAUSE_MISALIGN = 2'd2
  } fetch_cause_e;

  typedef struct packed {
    logic [PKG_ILEN-1:0] instr;
    logic [PKG_XLEN-1:0] pc;
    fetch_cause_e        cause;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/ifetch_prefetch_if.sv
// Instruction memory request/response bus.
// Signals:
//   req, addr     request from the fetch stage
//   ready         request accepted when req && ready
//   valid         in-order response, always accepted
//   data, err     response payload and access-fault flag
// Modports: master = fetch stage, slave = instruction memory.
interface ifetch_prefetch_if #(
  parameter int XLEN = 64,
  parameter int ILEN = 32
);
  logic            req;
  logic [XLEN-1:0] addr;
  logic            ready;
  logic            valid;
  logic [ILEN-1:0] data;
  logic            err;

  modport master (output req, addr, input ready, valid, data, err);
  modport slave  (input req, addr, output ready, valid, data, err);
endinterface

// File: rtl/ifetch_prefetch_fifo.sv
// Module ifetch_fifo: synchronous FIFO with a clear input.
// DEPTH must be a power of two.
// Ports: clk, reset (sync, active-high), clear, push/din, pop/dout, count.
// Behaviour:
//   dout shows the head entry and is meaningful only when count != 0.
//   A push while full is accepted only if a pop happens in the same cycle.
module ifetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push, do_pop;

  assign do_pop  = pop && (count_reg != '0);
  assign do_push = push && ((count_reg != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: count gates every use of an entry.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (do_push && !clear && (wr_ptr_reg == PW'(gi))) mem[gi] <= din;
    end
  end

  assign dout  = mem[rd_ptr_reg];
  assign count = count_reg;
endmodule

// File: rtl/ifetch_prefetch.sv
// Pipelined instruction fetch with an in-order prefetch queue.
// Keeps up to MAX_OUTSTANDING imem requests in flight. Returned instructions
// are buffered in a DEPTH-entry queue that feeds decode.
// After a redirect or flush, responses to requests already in flight are
// counted as stale and dropped.
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   pc_valid, pc_next      redirect strobe and target
//   flush                  clear the queue and halt fetching
//   imem (master)          request/response bus
//   instr_valid/ready      queue head handshake toward decode
//   instruction, pc_current, instr_cause   head entry fields
// Optional: define IFETCH_PERF_EN to add the perf_fetched and perf_dropped
// saturating counters.
module ifetch_prefetch
  import ifetch_pkg::*;
#(
  parameter int              XLEN            = PKG_XLEN,
  parameter int              ILEN            = PKG_ILEN,
  parameter int              DEPTH           = 4,
  parameter int              MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = 64'h8000_0000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pc_valid,
  input  logic [XLEN-1:0]     pc_next,
  input  logic                flush,
  ifetch_prefetch_if.master   imem,
  output logic                instr_valid,
  input  logic                instr_ready,
  output logic [ILEN-1:0]     instruction,
  output logic [XLEN-1:0]     pc_current,
  output logic [1:0]          instr_cause
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]         perf_fetched,
  output logic [31:0]         perf_dropped
`endif
);
  localparam int OW = $clog2(MAX_OUTSTANDING+1);
  localparam int CW = $clog2(DEPTH+1);

  fetch_state_e    state_reg, state_next;
  logic [XLEN-1:0] fetch_pc_reg, fetch_pc_next;
  logic [XLEN-1:0] resp_pc_reg, resp_pc_next;
  logic [OW-1:0]   outstanding_reg, outstanding_next;
  logic [OW-1:0]   stale_reg, stale_next;
  logic            misalign_pend_reg, misalign_pend_next;

  fetch_entry_t    q_din, q_dout;
  logic            q_push, q_pop, q_clear;
  logic [CW-1:0]   q_count;

  logic            kill, resp, hs, fetched_ev, dropped_ev;

  ifetch_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (q_clear),
    .push  (q_push),
    .din   (q_din),
    .pop   (q_pop),
    .dout  (q_dout),
    .count (q_count)
  );

  assign kill = pc_valid || flush;
  // A response with nothing in flight is a protocol error and is ignored.
  assign resp = imem.valid && (outstanding_reg != '0);
  assign hs   = imem.req && imem.ready;

  // Credit check: queue entries plus live (non-stale) requests must leave room.
  assign imem.req = !reset && (state_reg == RUN) && !kill
                  && (32'(outstanding_reg) < 32'(MAX_OUTSTANDING))
                  && ((32'(q_count) + 32'(outstanding_reg) - 32'(stale_reg)) < 32'(DEPTH));
  assign imem.addr = fetch_pc_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg         <= RUN;
      fetch_pc_reg      <= RESET_PC;
      resp_pc_reg       <= RESET_PC;
      outstanding_reg   <= '0;
      stale_reg         <= '0;
      misalign_pend_reg <= 1'b0;
    end else begin
      state_reg         <= state_next;
      fetch_pc_reg      <= fetch_pc_next;
      resp_pc_reg       <= resp_pc_next;
      outstanding_reg   <= outstanding_next;
      stale_reg         <= stale_next;
      misalign_pend_reg <= misalign_pend_next;
    end
  end

  always_comb begin
    state_next         = state_reg;
    fetch_pc_next      = fetch_pc_reg;
    resp_pc_next       = resp_pc_reg;
    stale_next         = stale_reg;
    misalign_pend_next = misalign_pend_reg;
    outstanding_next   = outstanding_reg + OW'(hs) - OW'(resp);
    q_clear            = kill;
    q_push             = 1'b0;
    q_din              = '{instr: '0, pc: '0, cause: CAUSE_NONE};
    fetched_ev         = 1'b0;
    dropped_ev         = resp && (kill || (stale_reg != '0));

    if (kill) begin
      // Everything still in flight after this cycle belongs to the old stream.
      stale_next         = outstanding_next;
      misalign_pend_next = 1'b0;
      if (pc_valid) begin
        fetch_pc_next = pc_next;
        resp_pc_next  = pc_next;
        if (pc_next[1:0] != 2'b00) begin
          state_next         = HALT;
          misalign_pend_next = 1'b1;
        end else begin
          state_next = RUN;
        end
      end else begin
        state_next = HALT;
      end
    end else begin
      if (hs) fetch_pc_next = fetch_pc_reg + XLEN'(PC_STEP);
      if (misalign_pend_reg) begin
        q_push             = 1'b1;
        q_din              = '{instr: '0, pc: resp_pc_reg, cause: CAUSE_MISALIGN};
        misalign_pend_next = 1'b0;
      end
      if (resp) begin
        if (stale_reg != '0) begin
          stale_next = stale_reg - 1'b1;
        end else if (state_reg == RUN) begin
          q_push       = 1'b1;
          fetched_ev   = 1'b1;
          q_din        = '{instr: imem.data, pc: resp_pc_reg,
                           cause: imem.err ? CAUSE_ACCESS : CAUSE_NONE};
          resp_pc_next = resp_pc_reg + XLEN'(PC_STEP);
          if (imem.err) state_next = HALT;
        end
      end
    end
  end

  assign instr_valid = (q_count != '0);
  assign q_pop       = instr_valid && instr_ready;
  assign instruction = instr_valid ? q_dout.instr : '0;
  assign pc_current  = instr_valid ? q_dout.pc : RESET_PC;
  assign instr_cause = instr_valid ? q_dout.cause : 2'b00;

`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetched_reg, perf_dropped_reg;
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched_reg <= '0;
      perf_dropped_reg <= '0;
    end else begin
      if (fetched_ev && (perf_fetched_reg != '1)) perf_fetched_reg <= perf_fetched_reg + 1'b1;
      if (dropped_ev && (perf_dropped_reg != '1)) perf_dropped_reg <= perf_dropped_reg + 1'b1;
    end
  end
  assign perf_fetched = perf_fetched_reg;
  assign perf_dropped = perf_dropped_reg;
`else
  logic unused_perf;
  assign unused_perf = fetched_ev ^ dropped_ev;
`endif

  a_no_orphan_resp: assert property (@(posedge clk) disable iff (reset)
    imem.valid |-> (outstanding_reg != '0));
endmodule

// File: tb/tb_ifetch_prefetch.sv
module tb_ifetch_prefetch;
  import ifetch_pkg::*;

  localparam int          XLEN     = 64;
  localparam int          ILEN     = 32;
  localparam int          DEPTH    = 4;
  localparam int          MAXO     = 2;
  localparam logic [63:0] RESET_PC = 64'h8000_0000;

  logic            clk = 1'b0;
  logic            reset, pc_valid, flush, instr_ready, instr_valid;
  logic [XLEN-1:0] pc_next, pc_current;
  logic [ILEN-1:0] instruction;
  logic [1:0]      instr_cause;
`ifdef IFETCH_PERF_EN
  logic [31:0]     perf_fetched, perf_dropped;
`endif

  ifetch_prefetch_if #(.XLEN(XLEN), .ILEN(ILEN)) imem ();

  ifetch_prefetch #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH),
                    .MAX_OUTSTANDING(MAXO), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .reset       (reset),
    .pc_valid    (pc_valid),
    .pc_next     (pc_next),
    .flush       (flush),
    .imem        (imem),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instruction (instruction),
    .pc_current  (pc_current),
    .instr_cause (instr_cause)
`ifdef IFETCH_PERF_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_dropped(perf_dropped)
`endif
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;

  // Memory environment: in-order responses, lat cycles after acceptance.
  int          lat = 1;
  logic [63:0] err_addr = '1;
  typedef struct { int due; logic [63:0] addr; } mreq_t;
  mreq_t mq[$];

  // Reference model: expected queue contents plus in-flight/stale counts.
  typedef struct { logic [31:0] instr; logic [63:0] pc; logic [1:0] cause; } ent_t;
  ent_t        m_q[$];
  bit          m_run, m_pend;
  logic [63:0] m_fetch, m_resp;
  int          m_out, m_stale, m_fetched, m_dropped;

  logic [63:0] req_log[$];
  ent_t        pop_log[$];
  int          first_req_cyc, first_valid_cyc;

  function automatic logic [31:0] mem_data(input logic [63:0] a);
    return a[31:0] ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic bit model_req();
    return !reset && m_run && !flush && !pc_valid && (m_out < MAXO)
           && ((m_q.size() + m_out - m_stale) < DEPTH);
  endfunction

  task automatic model_update(input bit resp);
    bit   hs, pop;
    ent_t e;
    hs  = model_req() && imem.ready;
    pop = (m_q.size() > 0) && instr_ready;
    if (reset) begin
      m_q.delete(); mq.delete();
      m_run = 1; m_pend = 0; m_fetch = RESET_PC; m_resp = RESET_PC;
      m_out = 0; m_stale = 0; m_fetched = 0; m_dropped = 0;
      return;
    end
    if (resp && m_out == 0) resp = 0;
    m_out = m_out + int'(hs) - int'(resp);
    if (pc_valid || flush) begin
      if (resp) m_dropped++;
      m_q.delete();
      m_stale = m_out;
      m_pend  = 0;
      if (pc_valid) begin
        m_fetch = pc_next; m_resp = pc_next;
        if (pc_next[1:0] != 2'b00) begin m_run = 0; m_pend = 1; end
        else m_run = 1;
      end else m_run = 0;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (m_pend) begin
        e = '{32'h0, m_resp, 2'd2};
        m_q.push_back(e);
        m_pend = 0;
      end
      if (resp) begin
        if (m_stale > 0) begin
          m_stale--; m_dropped++;
        end else if (m_run) begin
          e = '{mem_data(m_resp), m_resp, (m_resp == err_addr) ? 2'd1 : 2'd0};
          m_q.push_back(e);
          m_fetched++;
          if (m_resp == err_addr) m_run = 0;
          m_resp = m_resp + 64'd4;
        end
      end
      if (hs) m_fetch = m_fetch + 64'd4;
    end
  endtask

  // One clock cycle. Entered and left at the falling edge.
  task automatic step();
    bit   mreq, resp;
    ent_t e;
    if (!reset && mq.size() > 0 && mq[0].due <= cyc) begin
      imem.valid = 1'b1;
      imem.data  = mem_data(mq[0].addr);
      imem.err   = (mq[0].addr == err_addr);
      void'(mq.pop_front());
    end else begin
      imem.valid = 1'b0; imem.data = '0; imem.err = 1'b0;
    end
    resp = imem.valid;
    #1;
    mreq = model_req();
    chk("imem_req", 64'(imem.req), 64'(mreq));
    if (mreq) chk("imem_addr", imem.addr, m_fetch);
    chk("instr_valid", 64'(instr_valid), 64'(m_q.size() > 0));
    if (m_q.size() > 0) begin
      chk("instruction", 64'(instruction), 64'(m_q[0].instr));
      chk("pc_current", pc_current, m_q[0].pc);
      chk("instr_cause", 64'(instr_cause), 64'(m_q[0].cause));
    end
`ifdef IFETCH_PERF_EN
    chk("perf_fetched", 64'(perf_fetched), 64'(m_fetched));
    chk("perf_dropped", 64'(perf_dropped), 64'(m_dropped));
`endif
    if (imem.req && imem.ready) begin
      $display("cyc %0d REQ addr=%h", cyc, imem.addr);
      req_log.push_back(imem.addr);
      mq.push_back('{cyc + lat, imem.addr});
      if (first_req_cyc < 0) first_req_cyc = cyc;
    end
    if (instr_valid && instr_ready) begin
      $display("cyc %0d POP pc=%h instr=%h cause=%0d", cyc, pc_current, instruction, instr_cause);
      e = '{instruction, pc_current, instr_cause};
      pop_log.push_back(e);
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
    end
    model_update(resp);
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_logs();
    req_log.delete(); pop_log.delete();
    first_req_cyc = -1; first_valid_cyc = -1;
  endtask

  task automatic do_reset();
    reset = 1'b1; pc_valid = 1'b0; flush = 1'b0;
    run(2);
    reset = 1'b0;
    clear_logs();
  endtask

  task automatic redirect(input logic [63:0] tgt);
    pc_valid = 1'b1; pc_next = tgt;
    step();
    pc_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; pc_valid = 1'b0; pc_next = '0; flush = 1'b0; instr_ready = 1'b1;
    imem.ready = 1'b1; imem.valid = 1'b0; imem.data = '0; imem.err = 1'b0;
    @(negedge clk);
    model_update(1'b0);
    clear_logs();

    // Reset state.
    run(2);
    chk("rst_imem_req", 64'(imem.req), 64'd0);
    chk("rst_instr_valid", 64'(instr_valid), 64'd0);
    chk("rst_instruction", 64'(instruction), 64'd0);
    chk("rst_pc_current", pc_current, RESET_PC);
    chk("rst_instr_cause", 64'(instr_cause), 64'd0);

    // Back-to-back fetch after reset, 1-cycle memory.
    lat = 1; instr_ready = 1'b1;
    do_reset();
    run(8);
    chk("s1_req0", req_log[0], 64'h8000_0000);
    chk("s1_req1", req_log[1], 64'h8000_0004);
    chk("s1_req2", req_log[2], 64'h8000_0008);
    chk("s1_valid_latency", 64'(first_valid_cyc - first_req_cyc), 64'd2);
    chk("s1_pop0_pc", pop_log[0].pc, 64'h8000_0000);
    chk("s1_pop0_instr", 64'(pop_log[0].instr), 64'h9357_9BDF);

    // Backpressure: queue fills to DEPTH, one pop frees one request.
    instr_ready = 1'b0;
    do_reset();
    run(10);
    chk("s2_req_count_full", 64'(req_log.size()), 64'd4);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    run(6);
    chk("s2_req_count_after_pop", 64'(req_log.size()), 64'd5);

    // Redirect with two requests in flight and a partly filled queue.
    lat = 3; instr_ready = 1'b0;
    do_reset();
    run(6);
    redirect(64'h8000_0100);
    chk("s3_queue_cleared", 64'(instr_valid), 64'd0);
    instr_ready = 1'b1;
    clear_logs();
    run(14);
    chk("s3_first_pc", pop_log[0].pc, 64'h8000_0100);
    chk("s3_second_pc", pop_log[1].pc, 64'h8000_0104);
`ifdef IFETCH_PERF_EN
    chk("s3_perf_dropped", 64'(perf_dropped), 64'd2);
`endif

    // Redirect in the same cycle as a response.
    lat = 1; instr_ready = 1'b1;
    do_reset();
    run(4);
    redirect(64'h8000_0300);
    clear_logs();
    run(6);
    chk("s4_first_pc", pop_log[0].pc, 64'h8000_0300);
`ifdef IFETCH_PERF_EN
    chk("s4_perf_dropped", 64'(perf_dropped), 64'd1);
`endif

    // Access fault on the second response, then resume via redirect.
    err_addr = 64'h8000_0004;
    do_reset();
    run(8);
    chk("s5_pop_count", 64'(pop_log.size()), 64'd2);
    chk("s5_cause0", 64'(pop_log[0].cause), 64'd0);
    chk("s5_cause1", 64'(pop_log[1].cause), 64'd1);
    chk("s5_fault_pc", pop_log[1].pc, 64'h8000_0004);
    chk("s5_req_count", 64'(req_log.size()), 64'd3);
    redirect(64'h9000_0000);
    run(4);
    chk("s5_resume_addr", req_log[3], 64'h9000_0000);
    err_addr = '1;

    // Misaligned redirect, then aligned recovery.
    do_reset();
    run(3);
    redirect(64'h8000_0002);
    clear_logs();
    run(6);
    chk("s6_pop_count", 64'(pop_log.size()), 64'd1);
    chk("s6_pc", pop_log[0].pc, 64'h8000_0002);
    chk("s6_cause", 64'(pop_log[0].cause), 64'd2);
    chk("s6_instr", 64'(pop_log[0].instr), 64'd0);
    chk("s6_no_req", 64'(req_log.size()), 64'd0);
    redirect(64'h8000_0200);
    run(3);
    chk("s6_recover_addr", req_log[0], 64'h8000_0200);

    // Flush alone halts fetching; a redirect restarts it.
    do_reset();
    run(3);
    flush = 1'b1;
    step();
    flush = 1'b0;
    clear_logs();
    run(5);
    chk("s7_no_req", 64'(req_log.size()), 64'd0);
    chk("s7_no_pop", 64'(pop_log.size()), 64'd0);
    redirect(64'h8000_0400);
    run(4);
    chk("s7_restart_addr", req_log[0], 64'h8000_0400);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
